// File: rtl/axi_wr_tlp_packer.sv
// AXI4 write burst to PCIe memory-write TLP packetizer.
// Header from AW + config registers, payload passed straight from W.
module axi_wr_tlp_packer #(
  parameter int DATA_W    = 128,
  parameter int ADDR_W    = 32,
  parameter int ID_W      = 4,
  parameter int MAX_BEATS = 8,
  parameter int BQ_DEPTH  = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                awvalid,
  output logic                awready,
  input  logic [ID_W-1:0]     awid,
  input  logic [ADDR_W-1:0]   awaddr,
  input  logic [7:0]          awlen,
  input  logic [2:0]          awsize,
  input  logic [1:0]          awburst,
  input  logic                wvalid,
  output logic                wready,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic                wlast,
  output logic                bvalid,
  input  logic                bready,
  output logic [ID_W-1:0]     bid,
  output logic [1:0]          bresp,
  input  logic [2:0]          cfg_fmt,
  input  logic [4:0]          cfg_type,
  input  logic [2:0]          cfg_tc,
  input  logic [15:0]         cfg_req_id,
  input  logic [15:0]         cfg_cpl_id,
  output logic                tlp_valid,
  input  logic                tlp_ready,
  output logic                tlp_sop,
  output logic                tlp_eop,
  output logic [2:0]          tlp_fmt,
  output logic [4:0]          tlp_type,
  output logic [2:0]          tlp_tc,
  output logic [9:0]          tlp_length,
  output logic [15:0]         tlp_req_id,
  output logic [15:0]         tlp_cpl_id,
  output logic [ADDR_W-1:0]   tlp_addr,
  output logic [DATA_W-1:0]   tlp_data
);

  localparam int STRB_W = DATA_W / 8;
  localparam int WPB    = DATA_W / 32;
  localparam int PW     = $clog2(BQ_DEPTH);
  localparam logic [2:0] SIZE = 3'($clog2(STRB_W));

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    DRAIN,
    RESP
  } state_t;

  state_t state, state_nx;

  logic [7:0]      len_q;
  logic [7:0]      cnt;
  logic            err;
  logic [ID_W-1:0] id_q;
  logic            aw_hs;
  logic            w_hs;
  logic            bad_req;
  logic            last_cnt;
  logic [9:0]      len_dw;
  logic            push;
  logic            pop;
  logic            bq_full;
  logic            bq_empty;

  logic [ID_W+1:0] bq_mem [BQ_DEPTH];
  logic [PW-1:0]   wp;
  logic [PW-1:0]   rp;
  logic [PW:0]     bq_cnt;

  assign aw_hs    = awvalid && awready;
  assign w_hs     = wvalid && wready;
  assign last_cnt = (cnt == len_q);
  assign len_dw   = (10'(awlen) + 10'd1) * 10'(WPB);
  assign bad_req  = ((9'(awlen) + 9'd1) > 9'(MAX_BEATS))
                 || (awburst != 2'b01)
                 || (awsize != SIZE);

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (aw_hs) state_nx = bad_req ? DRAIN : DATA;
      end
      DATA: begin
        if (w_hs) begin
          if (wlast)         state_nx = RESP;
          else if (last_cnt) state_nx = DRAIN;
        end
      end
      DRAIN: begin
        if (w_hs && wlast) state_nx = RESP;
      end
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // awready is held low while reset is asserted
  always_comb begin
    awready   = 1'b0;
    wready    = 1'b0;
    tlp_valid = 1'b0;
    tlp_sop   = 1'b0;
    tlp_eop   = 1'b0;
    push      = 1'b0;
    unique case (state)
      IDLE: awready = !bq_full && !rst_n;
      DATA: begin
        wready    = tlp_ready;
        tlp_valid = wvalid;
        tlp_sop   = (cnt == 8'd0);
        tlp_eop   = wlast || last_cnt;
      end
      DRAIN:   wready = 1'b1;
      RESP:    push   = 1'b1;
      default: ;
    endcase
  end

  assign tlp_data = wdata;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      tlp_fmt    <= '0;
      tlp_type   <= '0;
      tlp_tc     <= '0;
      tlp_length <= '0;
      tlp_req_id <= '0;
      tlp_cpl_id <= '0;
      tlp_addr   <= '0;
      id_q       <= '0;
      len_q      <= '0;
      cnt        <= '0;
      err        <= 1'b0;
    end else if (aw_hs) begin
      tlp_fmt    <= cfg_fmt;
      tlp_type   <= cfg_type;
      tlp_tc     <= cfg_tc;
      tlp_length <= len_dw;
      tlp_req_id <= cfg_req_id;
      tlp_cpl_id <= cfg_cpl_id;
      tlp_addr   <= awaddr;
      id_q       <= awid;
      len_q      <= awlen;
      cnt        <= '0;
      err        <= bad_req;
    end else if (state == DATA && w_hs) begin
      cnt <= cnt + 8'd1;
      // partial strobe, early wlast or missing wlast
      if (wstrb != '1 || (wlast != last_cnt)) err <= 1'b1;
    end
  end

  assign bq_full  = (bq_cnt == (PW+1)'(BQ_DEPTH));
  assign bq_empty = (bq_cnt == '0);
  assign bvalid   = !bq_empty;
  assign pop      = bvalid && bready;
  assign bid      = bq_empty ? '0 : bq_mem[rp][ID_W+1:2];
  assign bresp    = bq_empty ? '0 : bq_mem[rp][1:0];

  always_ff @(posedge clk) begin
    if (push) bq_mem[wp] <= {id_q, err ? 2'b10 : 2'b00};
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      wp     <= '0;
      rp     <= '0;
      bq_cnt <= '0;
    end else begin
      if (push) wp <= wp + PW'(1);
      if (pop)  rp <= rp + PW'(1);
      unique case ({push, pop})
        2'b10:   bq_cnt <= bq_cnt + (PW+1)'(1);
        2'b01:   bq_cnt <= bq_cnt - (PW+1)'(1);
        default: bq_cnt <= bq_cnt;
      endcase
    end
  end

endmodule

// File: doc/axi_wr_tlp_packer.md
# axi_wr_tlp_packer

Parametrised AXI4 write-to-TLP packetizer in the PCIe block. It accepts an AXI write burst on AW/W and stamps it with the APB-programmed header fields (fmt, type, tc, requester/completer ID). It emits a memory-write TLP as a header plus an sop/eop-delimited payload stream, then returns the AXI B response. It supersedes the single-beat header/data path: bus width, burst depth and B-response queue depth are configurable, and protocol violations are checked.

## Interface
- DATA_W, 128, AXI W / TLP payload width in bits; power of two, ≥32
- ADDR_W, 32, address width
- ID_W, 4, AXI ID width
- MAX_BEATS, 8, largest burst forwarded (awlen+1); larger bursts are rejected
- BQ_DEPTH, 4, B-response queue depth; power of two
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-high (asserted = 1)
- awvalid/awready  in/out  1  AW handshake
- awid  in  ID_W; awaddr  in  ADDR_W; awlen  in  8; awsize  in  3; awburst  in  2
- wvalid/wready  in/out  1  W handshake; wdata  in  DATA_W; wstrb  in  DATA_W/8; wlast  in  1
- bvalid/bready  out/in  1  B handshake; bid  out  ID_W; bresp  out  2
- cfg_fmt  in  3; cfg_type  in  5; cfg_tc  in  3; cfg_req_id  in  16; cfg_cpl_id  in  16  APB config registers; sampled on AW accept
- tlp_valid/tlp_ready  out/in  1  payload handshake
- tlp_sop, tlp_eop  out  1  first/last payload beat markers
- tlp_fmt 3, tlp_type 5, tlp_tc 3, tlp_length 10, tlp_req_id 16, tlp_cpl_id 16, tlp_addr ADDR_W  out  header, held for the whole packet
- tlp_data  out  DATA_W  payload

## Operation
- FSM states: IDLE, DATA, DRAIN, RESP.
- IDLE: awready=1 only when the B queue is not full. On an AW handshake:
  - latch id, addr and cfg_* into the header registers;
  - tlp_length = (awlen+1)·DATA_W/32, truncated to 10 bits;
  - beat counter = 0; err = 0.
- Reject conditions (checked at AW accept): awlen+1 > MAX_BEATS, awburst≠2'b01, or awsize≠log2(DATA_W/8).
  - On reject: err=1, go to DRAIN, no TLP is emitted.
  - Otherwise go to DATA.
- DATA: combinational pass-through.
  - tlp_valid=wvalid, wready=tlp_ready, tlp_data=wdata.
  - tlp_sop=1 when beat counter = 0.
  - tlp_eop=1 when wlast=1 or beat counter = awlen.
  - On each handshake, the counter increments.
- Boundary conditions in DATA:
  - Early wlast (counter < awlen): eop on that beat, err=1, go to RESP.
  - Counter reaches awlen without wlast: eop on that beat, err=1, go to DRAIN.
  - Counter = awlen with wlast: go to RESP.
  - Any handshaked beat with wstrb ≠ all-ones: err=1; data is still forwarded unchanged.
- DRAIN: wready=1, tlp_valid=0. Consume W beats until a wlast handshake, then go to RESP.
- RESP: push {id, err ? 2'b10 : 2'b00} into the B queue, then go to IDLE.
- B queue (FIFO, BQ_DEPTH entries):
  - bvalid = not empty; bid/bresp = head entry; pop on bvalid&bready.
  - Simultaneous push and pop are both honoured; the count is unchanged.
- W beats presented while in IDLE stall (wready=0); they are never dropped.
- Reset mid-packet: the packet is abandoned and the queue is emptied. The master must re-issue.

## Timing
- Reset values: awready=0, wready=0, bvalid=0, bid=0, bresp=0, tlp_valid=0, tlp_sop=0, tlp_eop=0, all tlp_* header outputs=0. State=IDLE, queue empty.
- AW-to-first-payload: header is valid the cycle after the AW handshake. The first W beat can handshake in that same cycle.
- Payload latency: 0 cycles (combinational W→TLP). Throughput is 1 beat/cycle with tlp_ready=1.
- The last beat's handshake moves the FSM to RESP. The entry is pushed at the end of that RESP cycle, so bvalid rises 2 cycles after the last W handshake, provided the queue was empty.
- awready can reassert 2 cycles after the last W handshake, giving a minimum 1 idle cycle between packets.
- Header outputs do not change between AW accept and the next AW accept.
- tlp_valid, once high, must not be retracted by the block while tlp_ready=0. This holds as long as the master obeys AXI wvalid stability.

## Test plan
- DATA_W=128, one write: awaddr=0, awlen=0, awid=0, wdata={4{32'h01234567}}, cfg=0x01234567 pattern → one TLP beat with sop=eop=1, length=4, addr=0, data matches; B bid=0, bresp=00.
- Six back-to-back writes, addr alternating 0/32, ids 0..5, bready=1 → six TLPs in order; B ids 0..5 all OKAY; minimum 1-cycle gap between packets.
- awlen=3, incrementing data, tlp_ready toggling 1/0 → 4 beats, sop on beat 0 only, eop on beat 3, length=16, no data lost or duplicated.
- awlen=3 with wlast on beat 1 → eop on beat 1, bresp=10. Then awlen=1 with wlast on beat 3 → 2 TLP beats, 2 beats drained, bresp=10.
- awlen=MAX_BEATS (9 beats), and separately awburst=FIXED → no tlp_valid, all W beats consumed, bresp=10 with the correct bid.
- bready=0 through 5 writes, BQ_DEPTH=4 → awready stays low after 4 responses are queued. Release bready → 4 B responses, then the 5th write proceeds. Assert rst_n during a DATA beat → all outputs return to reset values.
